// File: rtl/pipe_pkg.sv
// Shared pipeline control types: the execute-to-memory control bundle and the
// all-zero bubble value that empty/flushed slots carry.
package pipe_pkg;

  typedef struct packed {
    logic [1:0] byte_acc;
    logic [2:0] result_sel;
    logic       mem_write;
    logic [2:0] byte_sel;
    logic       reg_write;
  } mem_ctrl_t;

  localparam int        MEM_CTRL_W  = $bits(mem_ctrl_t);
  localparam mem_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid/ctrl/data flops with ready/valid handshake and flush.
// With PIPE_SKID_EN defined the slot adds a one-entry skid and a registered up_ready.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = MEM_CTRL_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        cnt
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(CTRL_BUBBLE);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign dn_valid = valid_q;
  assign dn_ctrl  = ctrl_q;
  assign dn_data  = data_q;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              pop, push;

  assign up_ready = ~skid_valid_q;
  assign pop      = valid_q & dn_ready;
  assign push     = up_valid & ~skid_valid_q;
  assign cnt      = {1'b0, valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      valid_d      = 1'b0;
      ctrl_d       = BUBBLE;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = BUBBLE;
    end else if (skid_valid_q) begin
      // skid drains into main before any new input is taken
      if (pop) begin
        ctrl_d       = skid_ctrl_q;
        data_d       = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = BUBBLE;
      end
    end else if (valid_q && !pop) begin
      if (push) begin
        skid_valid_d = 1'b1;
        skid_ctrl_d  = up_ctrl;
        skid_data_d  = up_data;
      end
    end else if (push) begin
      valid_d = 1'b1;
      ctrl_d  = up_ctrl;
      data_d  = up_data;
    end else begin
      valid_d = 1'b0;
      ctrl_d  = BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign up_ready = ~valid_q | dn_ready;
  assign cnt      = {1'b0, valid_q};

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = BUBBLE;
    end else if (up_ready) begin
      valid_d = up_valid;
      ctrl_d  = up_valid ? up_ctrl : BUBBLE;
      if (up_valid) data_d = up_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_reg.sv
// Chain of DEPTH pipe_slot instances with bubble-zeroed control and flush.
// Optional macro PIPE_SKID_EN: per-slot skid entries, registered ready, capacity 2*DEPTH.
module pipe_ctrl_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = MEM_CTRL_W,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CTRL_W-1:0]              in_ctrl,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CTRL_W-1:0]              out_ctrl,
  output logic [DATA_W-1:0]              out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic [DEPTH-1:0]             sv, sr;
  logic [DEPTH-1:0][CTRL_W-1:0] sc;
  logic [DEPTH-1:0][DATA_W-1:0] sd;
  logic [DEPTH-1:0][1:0]        cnt;

  // slot 0 faces upstream, slot DEPTH-1 is the head
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              up_v, dn_r;
    logic [CTRL_W-1:0] up_c;
    logic [DATA_W-1:0] up_d;

    if (k == 0) begin : g_first
      assign up_v = in_valid;
      assign up_c = in_ctrl;
      assign up_d = in_data;
    end else begin : g_mid
      assign up_v = sv[k-1];
      assign up_c = sc[k-1];
      assign up_d = sd[k-1];
    end

    if (k == DEPTH-1) begin : g_head
      assign dn_r = out_ready;
    end else begin : g_body
      assign dn_r = sr[k+1];
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (up_v),
      .up_ready (sr[k]),
      .up_ctrl  (up_c),
      .up_data  (up_d),
      .dn_valid (sv[k]),
      .dn_ready (dn_r),
      .dn_ctrl  (sc[k]),
      .dn_data  (sd[k]),
      .cnt      (cnt[k])
    );
  end

  assign in_ready  = sr[0] & ~flush & ~reset;
  assign out_valid = sv[DEPTH-1];
  assign out_ctrl  = sc[DEPTH-1];
  assign out_data  = sd[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OCC_W'(cnt[k]);
  end

endmodule

// File: tb/tb_pipe_ctrl_reg.sv
// Randomized and directed bench for pipe_ctrl_reg against a FIFO reference
// (accepted beats in order, occupancy = accepted - consumed, zeroed by flush).
module tb_pipe_ctrl_reg;

  localparam int CW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int OW    = $clog2(2*DEPTH+1);
`ifdef PIPE_SKID_EN
  localparam int CAP = 2*DEPTH;
`else
  localparam int CAP = DEPTH;
`endif

  logic          clk, reset;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [OW-1:0] occupancy;

  logic          in_valid1, in_ready1, out_valid1, out_ready1;
  logic [CW-1:0] in_ctrl1, out_ctrl1;
  logic [DW-1:0] in_data1, out_data1;
  logic [1:0]    occupancy1;

  pipe_ctrl_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy)
  );

  pipe_ctrl_reg #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_ctrl(in_ctrl1), .in_data(in_data1), .flush(1'b0),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1),
    .out_data(out_data1), .occupancy(occupancy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_deq = 0;
  logic last_acc;
  logic [CW+DW-1:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: check outputs against the model, then advance the model on the edge
  task automatic step();
    logic acc, deq;
    logic [CW+DW-1:0] h;
    #1;
    if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
    if (out_valid) begin
      if (q.size() == 0) chk("phantom_beat", 64'(out_valid), 64'(0));
      else begin
        h = q[0];
        chk("head_ctrl", 64'(out_ctrl), 64'(h[CW+DW-1:DW]));
        chk("head_data", 64'(out_data), 64'(h[DW-1:0]));
      end
    end
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    if (flush) chk("rdy_flush", 64'(in_ready), 64'(0));
`ifdef PIPE_SKID_EN
    else if (q.size() == CAP) chk("rdy_full", 64'(in_ready), 64'(0));
`else
    else chk("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) || out_ready));
    if (q.size() == DEPTH) chk("full_valid", 64'(out_valid), 64'(1));
`endif
    acc = in_valid && in_ready;
    deq = out_valid && out_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (deq && q.size() > 0) begin q.delete(0); n_deq++; end
      if (acc) q.push_back({in_ctrl, in_data});
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic r);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = $urandom;
    out_ready = r;
  endtask

  initial begin
    logic [CW-1:0] exp_c[5];
    logic          exp_v[5];
    int            n_acc;
    reset = 1'b1; flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    in_valid1 = 1'b0; in_ctrl1 = '0; in_data1 = '0; out_ready1 = 1'b1;
    #2;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'(1));

    // basic latency: three back-to-back beats, head two edges after acceptance
    exp_c = '{10'h000, 10'h3FF, 10'h155, 10'h2AA, 10'h000};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, exp_c[i+1], 1'b1); else drive(1'b0, '0, 1'b1);
      step();
      chk("lat_valid", 64'(out_valid), 64'(exp_v[i]));
      chk("lat_ctrl", 64'(out_ctrl), 64'(exp_c[i]));
    end

    // stall fill, then release and drain in order
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, CW'(10'h010 + i), 1'b0);
      step();
      if (last_acc) n_acc++;
    end
    chk("stall_accepted", 64'(n_acc), 64'(CAP));
    drive(1'b0, '0, 1'b0);
    #1 chk("stall_in_ready", 64'(in_ready), 64'(0));
    chk("stall_occ", 64'(occupancy), 64'(CAP));
    n_deq = 0;
    for (int i = 0; i < 2*CAP + 4; i++) begin drive(1'b0, '0, 1'b1); step(); end
    chk("drain_count", 64'(n_deq), 64'(CAP));
    chk("drain_empty", 64'(out_valid), 64'(0));

    // flush while full, with an input beat offered in the flush cycle
    for (int i = 0; i < CAP; i++) begin drive(1'b1, CW'(10'h020 + i), 1'b0); step(); end
    drive(1'b1, 10'h0AA, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_ctrl", 64'(out_ctrl), 64'(0));
    chk("flush_occ", 64'(occupancy), 64'(0));
    for (int i = 0; i < 4; i++) begin drive(1'b0, '0, 1'b1); step(); end

    // same-cycle enqueue/dequeue on a full DEPTH=1 chain
    in_valid1 = 1'b1; in_ctrl1 = 10'h101; in_data1 = 32'h1; out_ready1 = 1'b0;
    @(negedge clk);
    chk("d1_full_occ", 64'(occupancy1), 64'(1));
    in_ctrl1 = 10'h102; in_data1 = 32'h2; out_ready1 = 1'b1;
    #1 chk("d1_in_ready", 64'(in_ready1), 64'(1));
    @(negedge clk);
    chk("d1_occ", 64'(occupancy1), 64'(1));
    chk("d1_ctrl", 64'(out_ctrl1), 64'(10'h102));
    chk("d1_data", 64'(out_data1), 64'(32'h2));
    in_valid1 = 1'b0;

    // asynchronous reset between edges with two beats in flight
    for (int i = 0; i < 2; i++) begin drive(1'b1, CW'(10'h030 + i), 1'b0); step(); end
    drive(1'b0, '0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_ctrl", 64'(out_ctrl), 64'(0));
    chk("arst_occ", 64'(occupancy), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(0));
    chk("arst_d1_valid", 64'(out_valid1), 64'(0));
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 10'h001, 1'b1);
    step();
    drive(1'b0, '0, 1'b1);
    chk("new_beat_early", 64'(out_valid), 64'(0));
    step();
    chk("new_beat_valid", 64'(out_valid), 64'(1));
    chk("new_beat_ctrl", 64'(out_ctrl), 64'(10'h001));
    step();
    chk("new_beat_gone", 64'(out_valid), 64'(0));

    // random traffic with rare flushes
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom), 1'($urandom_range(0, 3) != 0));
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;
    for (int i = 0; i < 2*CAP + 4; i++) begin drive(1'b0, '0, 1'b1); step(); end
    chk("final_empty_q", 64'(q.size()), 64'(0));
    chk("final_valid", 64'(out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
